// File: rtl/imem_boot_loader_if.sv
// Word stream channel feeding the instruction-memory boot loader.
// The source drives valid/data and the loader answers with ready.
interface imem_boot_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader for the single-cycle core's instruction RAM.
// Accepts a header word, N payload words and an additive checksum over a
// valid/ready stream, writes the payload to sequential RAM words, and keeps
// the core held in reset until a load has finished with a matching checksum.
module imem_boot_loader #(
  parameter int          ADDR_W = 5,
  parameter int          DEPTH  = 32,
  parameter logic [15:0] MAGIC  = 16'hB007
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_boot_loader_if.slave   inBus,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                core_rst,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     words_loaded
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] CHK  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;

  localparam logic [15:0]     DEPTH_W = 16'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  logic [2:0]      state;
  logic [ADDR_W:0] loadTarget;
  logic [31:0]     checkSum;
  logic [15:0]     hdrCount;
  logic            hdrOk;
  logic            accept;

  // Ready depends on state only, so the source never sees a combinational path from valid.
  assign inBus.in_ready = (state == HDR) || (state == LOAD) || (state == CHK);
  assign accept         = inBus.in_valid && inBus.in_ready;
  assign hdrCount       = inBus.in_data[15:0];
  assign hdrOk          = (inBus.in_data[31:16] == MAGIC) && (hdrCount != 16'd0) &&
                          (hdrCount <= DEPTH_W);

  // Session sequencer: words_loaded doubles as the write index, and the RAM
  // strobe is a registered one-cycle pulse following each accepted payload word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_rst     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      checkSum     <= '0;
      loadTarget   <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= HDR;
        end
        HDR: begin
          if (accept) begin
            if (hdrOk) begin
              state        <= LOAD;
              words_loaded <= '0;
              checkSum     <= '0;
              loadTarget   <= hdrCount[ADDR_W:0];
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            mem_we       <= 1'b1;
            mem_addr     <= words_loaded[ADDR_W-1:0];
            mem_wdata    <= inBus.in_data;
            checkSum     <= checkSum + inBus.in_data;
            words_loaded <= words_loaded + CNT_ONE;
            if (words_loaded == loadTarget - CNT_ONE) state <= CHK;
          end
        end
        CHK: begin
          if (accept) begin
            if (inBus.in_data == checkSum) begin
              state    <= DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state    <= HDR;
            done     <= 1'b0;
            core_rst <= 1'b1;
          end
        end
        ERR: begin
          if (start) begin
            state <= HDR;
            err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: each session's expected RAM writes
// are queued as payload is issued and checked by a separate write monitor;
// session outcomes come from a simple header/sum reference model.
module tb_imem_boot_loader;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  imem_boot_loader_if bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAGIC(16'hB007)) dut (
    .clk(clk), .rst(rst), .start(start), .inBus(bus),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } memWriteT;

  memWriteT    expQ[$];
  logic [31:0] payQ[$];
  int          compareCount  = 0;
  int          mismatchCount = 0;
  int          modelWords    = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Write monitor: every RAM strobe must match the oldest queued write.
  always @(negedge clk) begin : writeMonitor
    memWriteT e;
    if (mem_we === 1'b1) begin
      if (expQ.size() == 0) begin
        compareCount++;
        mismatchCount++;
        $display("[TB] FAIL unexpectedWrite: got write addr %0d data %0h expected none at %0t",
                 mem_addr, mem_wdata, $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("writeAddr", 32'(mem_addr), 32'(e.addr));
        checkOutput("writeData", mem_wdata, e.data);
      end
    end
  end

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".inReady"}, 32'(bus.in_ready), 32'd0);
    checkOutput({tag, ".memWe"}, 32'(mem_we), 32'd0);
    checkOutput({tag, ".coreRst"}, 32'(core_rst), 32'd1);
    checkOutput({tag, ".done"}, 32'(done), 32'd0);
    checkOutput({tag, ".err"}, 32'(err), 32'd0);
    checkOutput({tag, ".wordsLoaded"}, 32'(words_loaded), 32'(modelWords));
  endtask

  task automatic startPulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("startInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("startCoreRst", 32'(core_rst), 32'd1);
    checkOutput("startDone", 32'(done), 32'd0);
    checkOutput("startErr", 32'(err), 32'd0);
  endtask

  task automatic sendWord(input logic [31:0] w, input int maxStall);
    int stall;
    int guard;
    stall = (maxStall > 0) ? int'($urandom_range(0, maxStall)) : 0;
    for (int s = 0; s < stall; s++) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      compareCount++;
      mismatchCount++;
      $display("[TB] FAIL handshake: got in_ready %b expected 1 within 20 cycles", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  // One load session using payQ as payload; checksum sent is the true sum XOR chkXor.
  task automatic applyStimulus(input logic [31:0] hdr, input logic [31:0] chkXor,
                               input int maxStall, input bit midStart);
    int          n;
    bit          hdrValid;
    logic [31:0] sum;
    memWriteT    w;
    n        = int'(hdr[15:0]);
    hdrValid = (hdr[31:16] == 16'hB007) && (n >= 1) && (n <= DEPTH);
    startPulse();
    sendWord(hdr, maxStall);
    if (!hdrValid) begin
      @(negedge clk);
      checkOutput("badHdrErr", 32'(err), 32'd1);
      checkOutput("badHdrDone", 32'(done), 32'd0);
      checkOutput("badHdrCoreRst", 32'(core_rst), 32'd1);
      checkOutput("badHdrInReady", 32'(bus.in_ready), 32'd0);
      checkOutput("badHdrWords", 32'(words_loaded), 32'(modelWords));
      return;
    end
    sum = 32'd0;
    for (int i = 0; i < n; i++) begin
      w.addr = ADDR_W'(i);
      w.data = payQ[i];
      expQ.push_back(w);
      sum += payQ[i];
      sendWord(payQ[i], maxStall);
      if (midStart && i == 0 && n > 1) begin
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("midStartInReady", 32'(bus.in_ready), 32'd1);
      end
    end
    modelWords = n;
    sendWord(sum ^ chkXor, maxStall);
    @(negedge clk);
    checkOutput("endDone", 32'(done), (chkXor == 32'd0) ? 32'd1 : 32'd0);
    checkOutput("endErr", 32'(err), (chkXor == 32'd0) ? 32'd0 : 32'd1);
    checkOutput("endCoreRst", 32'(core_rst), (chkXor == 32'd0) ? 32'd0 : 32'd1);
    checkOutput("endInReady", 32'(bus.in_ready), 32'd0);
    checkOutput("endWords", 32'(words_loaded), 32'(n));
  endtask

  task automatic fillPayload(input int n);
    payQ.delete();
    for (int i = 0; i < n; i++) payQ.push_back($urandom);
  endtask

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;

    // Power-on reset and reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkIdle("reset");
    checkOutput("reset.memAddr", 32'(mem_addr), 32'd0);
    checkOutput("reset.memWdata", mem_wdata, 32'd0);

    // start and rst together: rst wins, loader stays idle
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkIdle("rstStart");

    // Clean three-word load
    payQ.delete();
    payQ.push_back(32'h00500093);
    payQ.push_back(32'h00A00113);
    payQ.push_back(32'h002081B3);
    applyStimulus(32'hB007_0003, 32'd0, 0, 1'b0);

    // Bad magic, then recovery with a good header
    applyStimulus(32'hDEAD_0004, 32'd0, 0, 1'b0);
    fillPayload(2);
    applyStimulus(32'hB007_0002, 32'd0, 0, 1'b0);

    // Checksum mismatch: payload 1, 2 with checksum 4 (true sum 3 XOR 7)
    payQ.delete();
    payQ.push_back(32'd1);
    payQ.push_back(32'd2);
    applyStimulus(32'hB007_0002, 32'd7, 0, 1'b0);

    // Length boundaries
    applyStimulus(32'hB007_0000, 32'd0, 0, 1'b0);
    applyStimulus(32'hB007_0021, 32'd0, 0, 1'b0);
    fillPayload(32);
    applyStimulus(32'hB007_0020, 32'd0, 0, 1'b0);

    // Stalls with start pulsed mid-load
    fillPayload(6);
    applyStimulus(32'hB007_0006, 32'd0, 3, 1'b1);

    // Reset after two of five words, with a word offered on the reset edge
    fillPayload(5);
    startPulse();
    sendWord(32'hB007_0005, 0);
    for (int i = 0; i < 2; i++) begin
      expQ.push_back('{addr: ADDR_W'(i), data: payQ[i]});
      sendWord(payQ[i], 0);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = payQ[2];
    @(posedge clk);
    #1 rst = 1'b0;
    bus.in_valid = 1'b0;
    modelWords = 0;
    @(negedge clk);
    checkIdle("midLoadReset");
    applyStimulus(32'hB007_0005, 32'd0, 1, 1'b0);

    // Randomized sessions
    for (int k = 0; k < 25; k++) begin
      int          n;
      logic [15:0] magic;
      logic [31:0] chkXor;
      n = int'($urandom_range(0, DEPTH + 2));
      magic = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'hB007;
      if (magic == 16'hB007 && $urandom_range(0, 9) == 0) magic = 16'h0BAD;
      chkXor = ($urandom_range(0, 3) == 0) ? ($urandom | 32'd1) : 32'd0;
      fillPayload((n <= DEPTH) ? n : 0);
      applyStimulus({magic, 16'(n)}, chkXor, int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0);
    end

    repeat (3) @(negedge clk);
    checkOutput("pendingWrites", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
